vram_write_arbiter: RTL and testbench

Single-port VRAM access arbiter for the GPU clock domain. It shares one VRAM port among three requesters: the renderer's read fetch, CPU bus writes into the 0x3700–0x3FFF VRAM window, and a low-priority DMA/fill engine. CPU writes are buffered in a small FIFO so that no write is lost while the renderer holds the port. It sits between the CPU bus address decode and the VRAM macros inside the top-level design.

---
 rtl/vram_write_arbiter_pkg.sv | 21 ++
 rtl/vram_write_arbiter_if.sv | 38 +++
 rtl/vram_write_arbiter_fifo.sv | 64 ++++++
 rtl/vram_write_arbiter.sv | 128 ++++++++++++
 tb/tb_vram_write_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/vram_write_arbiter_pkg.sv
// Shared constants and types for the VRAM port arbiter: window geometry,
// region offsets and the request-source encoding.
package vram_write_arbiter_pkg;

    localparam logic [15:0] VRAM_BASE        = 16'h3700;
    localparam logic [11:0] VRAM_SIZE        = 12'h900;

    localparam logic [11:0] REGION_PATTERN   = 12'h000;
    localparam logic [11:0] REGION_NAMETABLE = 12'h200;
    localparam logic [11:0] REGION_OBJECT    = 12'h400;
    localparam logic [11:0] REGION_TEXT      = 12'h7C0;
    localparam logic [11:0] REGION_COLOUR    = 12'h800;

    typedef enum logic [1:0] {
        SRC_IDLE = 2'd0,
        SRC_GPU  = 2'd1,
        SRC_CPU  = 2'd2,
        SRC_DMA  = 2'd3
    } vram_src_e;

endpackage

// File: rtl/vram_write_arbiter_if.sv
// Requester and VRAM-port signal bundle for the arbiter; the master side
// drives requests, the slave side (arbiter) drives grants and the port.
interface vram_write_arbiter_if #(
    parameter int ADDR_W = 12
);
    logic              cpu_wr_strobe;
    logic [ADDR_W-1:0] cpu_wr_addr;
    logic [7:0]        cpu_wr_data;
    logic              cpu_fifo_full;
    logic              cpu_overflow;
    logic              overflow_clr;
    logic              gpu_rd_req;
    logic [ADDR_W-1:0] gpu_rd_addr;
    logic              gpu_rd_grant;
    logic              dma_req;
    logic [ADDR_W-1:0] dma_addr;
    logic [7:0]        dma_data;
    logic              dma_ack;
    logic [ADDR_W-1:0] vram_addr;
    logic [7:0]        vram_wdata;
    logic              vram_we;
    logic              vram_re;

    modport master (
        output cpu_wr_strobe, cpu_wr_addr, cpu_wr_data, overflow_clr,
               gpu_rd_req, gpu_rd_addr, dma_req, dma_addr, dma_data,
        input  cpu_fifo_full, cpu_overflow, gpu_rd_grant, dma_ack,
               vram_addr, vram_wdata, vram_we, vram_re
    );

    modport slave (
        input  cpu_wr_strobe, cpu_wr_addr, cpu_wr_data, overflow_clr,
               gpu_rd_req, gpu_rd_addr, dma_req, dma_addr, dma_data,
        output cpu_fifo_full, cpu_overflow, gpu_rd_grant, dma_ack,
               vram_addr, vram_wdata, vram_we, vram_re
    );

endinterface

// File: rtl/vram_write_arbiter_fifo.sv
// vram_wr_fifo: synchronous FIFO for buffered CPU writes. An extra pointer
// bit separates full from empty; a push while full is taken only with a pop.
module vram_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W:0]   wr_ptr_r;
    logic [PTR_W:0]   rd_ptr_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                   (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign head  = mem_r[rd_ptr_r[PTR_W-1:0]];

    // Qualify requests against the current occupancy.
    always_comb begin
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
        if (pop && !empty) begin
            pop_ok_s = 1'b1;
        end else begin
            pop_ok_s = 1'b0;
        end
        if (push && (!full || pop_ok_s)) begin
            push_ok_s = 1'b1;
        end else begin
            push_ok_s = 1'b0;
        end
    end

    // Storage and pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(PTR_W+1){1'b0}};
            rd_ptr_r <= {(PTR_W+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r[PTR_W-1:0]] <= din;
                wr_ptr_r <= wr_ptr_r + {{PTR_W{1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{PTR_W{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/vram_write_arbiter.sv
// Fixed-priority single-port VRAM arbiter: GPU read > buffered CPU write >
// DMA write. Port outputs are registered one cycle after the grant decision.
module vram_write_arbiter
    import vram_write_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 12
) (
    input  logic                 clk_12_5875,
    input  logic                 rst_B,
    vram_write_arbiter_if.slave  bus
);
    localparam int ENTRY_W = ADDR_W + 8;

    logic [ENTRY_W-1:0] head_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               push_s;
    logic               pop_s;
    logic               ovf_set_s;
    vram_src_e          src_s;
    logic [ADDR_W-1:0]  sel_addr_s;
    logic [7:0]         sel_data_s;

    logic [ADDR_W-1:0]  vram_addr_r;
    logic [7:0]         vram_wdata_r;
    logic               vram_we_r;
    logic               vram_re_r;
    logic               overflow_r;

    vram_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk_12_5875),
        .rst_n (rst_B),
        .push  (push_s),
        .din   ({bus.cpu_wr_addr, bus.cpu_wr_data}),
        .pop   (pop_s),
        .head  (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Grant selection. A strobe into an empty FIFO is written straight
    // through so the minimum CPU latency is one cycle and a same-cycle DMA
    // request cannot overtake it.
    always_comb begin
        src_s      = SRC_IDLE;
        sel_addr_s = vram_addr_r;
        sel_data_s = vram_wdata_r;
        pop_s      = 1'b0;
        push_s     = 1'b0;
        if (bus.gpu_rd_req) begin
            src_s      = SRC_GPU;
            sel_addr_s = bus.gpu_rd_addr;
            push_s     = bus.cpu_wr_strobe;
        end else if (!fifo_empty_s) begin
            src_s      = SRC_CPU;
            pop_s      = 1'b1;
            sel_addr_s = head_s[ENTRY_W-1:8];
            sel_data_s = head_s[7:0];
            push_s     = bus.cpu_wr_strobe;
        end else if (bus.cpu_wr_strobe) begin
            src_s      = SRC_CPU;
            sel_addr_s = bus.cpu_wr_addr;
            sel_data_s = bus.cpu_wr_data;
        end else if (bus.dma_req) begin
            src_s      = SRC_DMA;
            sel_addr_s = bus.dma_addr;
            sel_data_s = bus.dma_data;
        end else begin
            src_s      = SRC_IDLE;
        end
    end

    assign ovf_set_s = bus.cpu_wr_strobe && fifo_full_s && !pop_s;

    // Registered VRAM port; idle cycles keep the last address and data.
    always_ff @(posedge clk_12_5875 or negedge rst_B) begin
        if (!rst_B) begin
            vram_addr_r  <= {ADDR_W{1'b0}};
            vram_wdata_r <= 8'h00;
            vram_we_r    <= 1'b0;
            vram_re_r    <= 1'b0;
        end else begin
            vram_addr_r  <= sel_addr_s;
            vram_wdata_r <= sel_data_s;
            case (src_s)
                SRC_GPU: begin
                    vram_we_r <= 1'b0;
                    vram_re_r <= 1'b1;
                end
                SRC_CPU, SRC_DMA: begin
                    vram_we_r <= 1'b1;
                    vram_re_r <= 1'b0;
                end
                default: begin
                    vram_we_r <= 1'b0;
                    vram_re_r <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow flag; a fresh drop outranks a same-cycle clear.
    always_ff @(posedge clk_12_5875 or negedge rst_B) begin
        if (!rst_B) begin
            overflow_r <= 1'b0;
        end else if (ovf_set_s) begin
            overflow_r <= 1'b1;
        end else if (bus.overflow_clr) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign bus.cpu_fifo_full = fifo_full_s;
    assign bus.cpu_overflow  = overflow_r;
    assign bus.gpu_rd_grant  = bus.gpu_rd_req;
    assign bus.dma_ack       = (src_s == SRC_DMA);
    assign bus.vram_addr     = vram_addr_r;
    assign bus.vram_wdata    = vram_wdata_r;
    assign bus.vram_we       = vram_we_r;
    assign bus.vram_re       = vram_re_r;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter: a queue-based reference model is
// compared every cycle, plus hand-computed expectations per scenario.
module tb_vram_write_arbiter;
    localparam int DEPTH = 4;
    localparam int AW    = 12;

    logic clk = 1'b0;
    logic rst_B;
    always #5 clk = ~clk;

    vram_write_arbiter_if #(.ADDR_W(AW)) vif();

    vram_write_arbiter #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk_12_5875 (clk),
        .rst_B       (rst_B),
        .bus         (vif)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: CPU writes are an ordered queue of {addr,data}.
    logic [19:0]   mq[$];
    logic          m_we, m_re, m_ovf;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_wdata;

    always @(posedge clk or negedge rst_B) begin
        if (!rst_B) begin
            mq.delete();
            m_we <= 1'b0; m_re <= 1'b0; m_ovf <= 1'b0;
            m_addr <= 12'h000; m_wdata <= 8'h00;
        end else begin
            m_ovf <= (m_ovf && !vif.overflow_clr) ||
                     (vif.gpu_rd_req && vif.cpu_wr_strobe && mq.size() == DEPTH);
            if (vif.gpu_rd_req) begin
                m_re <= 1'b1; m_we <= 1'b0; m_addr <= vif.gpu_rd_addr;
                if (vif.cpu_wr_strobe && mq.size() < DEPTH)
                    mq.push_back({vif.cpu_wr_addr, vif.cpu_wr_data});
            end else if (mq.size() > 0) begin
                m_re <= 1'b0; m_we <= 1'b1;
                m_addr <= mq[0][19:8]; m_wdata <= mq[0][7:0];
                void'(mq.pop_front());
                if (vif.cpu_wr_strobe) mq.push_back({vif.cpu_wr_addr, vif.cpu_wr_data});
            end else if (vif.cpu_wr_strobe) begin
                m_re <= 1'b0; m_we <= 1'b1;
                m_addr <= vif.cpu_wr_addr; m_wdata <= vif.cpu_wr_data;
            end else if (vif.dma_req) begin
                m_re <= 1'b0; m_we <= 1'b1;
                m_addr <= vif.dma_addr; m_wdata <= vif.dma_data;
            end else begin
                m_re <= 1'b0; m_we <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("m_vram_we",    vif.vram_we,       m_we);
        check("m_vram_re",    vif.vram_re,       m_re);
        check("m_vram_addr",  vif.vram_addr,     m_addr);
        check("m_vram_wdata", vif.vram_wdata,    m_wdata);
        check("m_overflow",   vif.cpu_overflow,  m_ovf);
        check("m_fifo_full",  vif.cpu_fifo_full, (mq.size() == DEPTH));
        check("m_gpu_grant",  vif.gpu_rd_grant,  vif.gpu_rd_req);
        check("m_dma_ack",    vif.dma_ack,
              vif.dma_req && !vif.gpu_rd_req && mq.size() == 0 && !vif.cpu_wr_strobe);
    end

    task automatic step();
        @(posedge clk);
        #1;
        vif.cpu_wr_strobe = 1'b0;
        vif.overflow_clr  = 1'b0;
    endtask

    task automatic strobe(input logic [AW-1:0] a, input logic [7:0] d);
        vif.cpu_wr_strobe = 1'b1;
        vif.cpu_wr_addr   = a;
        vif.cpu_wr_data   = d;
    endtask

    logic [7:0] dat[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int cnt;

    initial begin
        rst_B = 1'b1;
        vif.cpu_wr_strobe = 1'b0; vif.cpu_wr_addr = 12'h000; vif.cpu_wr_data = 8'h00;
        vif.overflow_clr = 1'b0;
        vif.gpu_rd_req = 1'b0; vif.gpu_rd_addr = 12'h123;
        vif.dma_req = 1'b0; vif.dma_addr = 12'h000; vif.dma_data = 8'h00;
        #2 rst_B = 1'b0;
        step();
        step();
        check("rst_we",   vif.vram_we, 1'b0);
        check("rst_re",   vif.vram_re, 1'b0);
        check("rst_addr", vif.vram_addr, 12'h000);
        check("rst_full", vif.cpu_fifo_full, 1'b0);
        check("rst_ovf",  vif.cpu_overflow, 1'b0);
        rst_B = 1'b1;
        step();

        // Minimum-latency CPU write.
        strobe(12'h000, 8'h99);
        step();
        check("t1_we",    vif.vram_we, 1'b1);
        check("t1_addr",  vif.vram_addr, 12'h000);
        check("t1_wdata", vif.vram_wdata, 8'h99);

        // Renderer holds the port 40 cycles while 4 writes queue.
        vif.gpu_rd_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i % 10 == 0) strobe(12'h400 + 12'(i / 10), dat[i / 10]);
            step();
            check("t2_hold_no_we", vif.vram_we, 1'b0);
        end
        vif.gpu_rd_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t2_drain_we",    vif.vram_we, 1'b1);
            check("t2_drain_addr",  vif.vram_addr, 12'h400 + 12'(k));
            check("t2_drain_wdata", vif.vram_wdata, dat[k]);
        end
        step();
        check("t2_idle_we", vif.vram_we, 1'b0);
        check("t2_ovf",     vif.cpu_overflow, 1'b0);

        // Five strobes under a held read: the fifth is dropped.
        vif.gpu_rd_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            strobe(12'h010 + 12'(i), 8'hA0 + 8'(i));
            step();
            if (i == 3) check("t3_full", vif.cpu_fifo_full, 1'b1);
            if (i == 4) check("t3_ovf_set", vif.cpu_overflow, 1'b1);
            step();
        end
        strobe(12'h0FF, 8'hEE);
        vif.overflow_clr = 1'b1;
        step();
        check("t3_set_wins", vif.cpu_overflow, 1'b1);
        vif.gpu_rd_req = 1'b0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (vif.vram_we) begin
                check("t3_order", vif.vram_wdata, 8'hA0 + 8'(cnt));
                cnt++;
            end
        end
        check("t3_write_count", cnt, 4);
        vif.overflow_clr = 1'b1;
        step();
        check("t3_ovf_clr", vif.cpu_overflow, 1'b0);

        // Same-cycle CPU strobe and DMA request: CPU goes first.
        strobe(12'h800, 8'hA5);
        vif.dma_req = 1'b1; vif.dma_addr = 12'h7C0; vif.dma_data = 8'h15;
        #1;
        check("t4_ack_wait", vif.dma_ack, 1'b0);
        step();
        check("t4_cpu_wdata", vif.vram_wdata, 8'hA5);
        #1;
        check("t4_ack", vif.dma_ack, 1'b1);
        step();
        vif.dma_req = 1'b0;
        check("t4_dma_we",    vif.vram_we, 1'b1);
        check("t4_dma_addr",  vif.vram_addr, 12'h7C0);
        check("t4_dma_wdata", vif.vram_wdata, 8'h15);
        step();
        check("t4_idle_we",   vif.vram_we, 1'b0);
        check("t4_idle_addr", vif.vram_addr, 12'h7C0);

        // Full FIFO with simultaneous pop and push.
        vif.gpu_rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            strobe(12'h020 + 12'(i), 8'h50 + 8'(i));
            step();
        end
        check("t5_full", vif.cpu_fifo_full, 1'b1);
        vif.gpu_rd_req = 1'b0;
        strobe(12'h024, 8'h54);
        step();
        check("t5_no_ovf",    vif.cpu_overflow, 1'b0);
        check("t5_still_full", vif.cpu_fifo_full, 1'b1);
        check("t5_first",     vif.vram_wdata, 8'h50);
        for (int k = 1; k < 5; k++) begin
            step();
            check("t5_drain", vif.vram_wdata, 8'h50 + 8'(k));
        end
        check("t5_empty", vif.cpu_fifo_full, 1'b0);

        // Reset mid-drain with 3 entries still queued.
        vif.gpu_rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            strobe(12'h030 + 12'(i), 8'h60 + 8'(i));
            step();
        end
        vif.gpu_rd_req = 1'b0;
        step();
        check("t6_first_write", vif.vram_wdata, 8'h60);
        rst_B = 1'b0;
        #1;
        check("t6_rst_we",   vif.vram_we, 1'b0);
        check("t6_rst_full", vif.cpu_fifo_full, 1'b0);
        check("t6_rst_addr", vif.vram_addr, 12'h000);
        step();
        rst_B = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("t6_no_stale", vif.vram_we, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
